branch_resolve_unit: RTL and testbench



---
 rtl/bru_pkg.sv | 28 ++
 rtl/bru_pred_fifo.sv | 80 ++++++++
 rtl/branch_resolve_unit.sv | 187 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction FIFO.
package bru_pkg;

    localparam int PC_W    = 16;
    localparam int ENTRY_W = 2 * PC_W;

    // The predictor uses all-ones as its invalid-entry marker.
    localparam logic [PC_W-1:0] PC_ALL_ONES = 16'hFFFF;
    localparam logic [15:0]     STAT_MAX    = 16'hFFFF;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_pc;
    } bru_entry_t;

    // Sequential next PC; wraps explicitly from all-ones to zero.
    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
        if (pc == PC_ALL_ONES) begin
            return 16'h0000;
        end else begin
            return pc + 16'd1;
        end
    endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// In-flight prediction FIFO: synchronous clear, empty flag, sticky overflow flag.
module bru_pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             full_s, rd_en_s, wr_en_s;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_s = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata  = mem_q[rd_ptr_q[AW-1:0]];
    assign ovf    = ovf_q;

    // Pointer/flag next state; a pop frees the slot a same-cycle push reuses.
    always_comb begin
        rd_en_s  = pop & ~empty;
        wr_en_s  = push & (~full_s | rd_en_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q | (~clr & push & full_s & ~rd_en_s);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s && !clr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks predictions against ID outcomes, updates the predictor,
// redirects and flushes on mispredict. Optional counters under macro BRU_STATS_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            if_valid,
    input  logic [PC_W-1:0] if_pc,
    input  logic [PC_W-1:0] if_pred_pc,
    input  logic            id_valid,
    input  logic            id_is_branch,
    input  logic            id_taken,
    input  logic [PC_W-1:0] id_target,
    output logic            upd_jump_n,
    output logic [PC_W-1:0] upd_from_pc,
    output logic [PC_W-1:0] upd_to_pc,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic            fifo_ovf
`ifdef BRU_STATS_EN
    ,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispred
`endif
);

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    bru_entry_t      head_s, wr_entry_s;
    logic            empty_s, pop_s, push_s, mispredict_s;
    logic [PC_W-1:0] actual_s;

    logic [0:0]      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            upd_jump_n_q, upd_jump_n_d;
    logic [PC_W-1:0] upd_from_pc_q, upd_from_pc_d;
    logic [PC_W-1:0] upd_to_pc_q, upd_to_pc_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic            flush_q, flush_d;

    bru_pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (mispredict_s),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wr_entry_s),
        .rdata (head_s),
        .empty (empty_s),
        .ovf   (fifo_ovf)
    );

    // Resolve the FIFO head against the ID outcome; recovery blocks both ends.
    always_comb begin
        pop_s        = id_valid & ~stall & ~empty_s & (state_q == ST_IDLE);
        actual_s     = id_taken ? id_target : pc_incr(head_s.pc);
        mispredict_s = pop_s & (actual_s != head_s.pred_pc);
        push_s       = if_valid & ~stall & (state_q == ST_IDLE) & ~mispredict_s;
        wr_entry_s   = '{pc: if_pc, pred_pc: if_pred_pc};
    end

    // Predictor table update; only branches write, fields hold otherwise.
    always_comb begin
        upd_jump_n_d  = 1'b1;
        upd_from_pc_d = upd_from_pc_q;
        upd_to_pc_d   = upd_to_pc_q;
        if (pop_s && id_is_branch) begin
            upd_jump_n_d  = 1'b0;
            upd_from_pc_d = head_s.pc;
            upd_to_pc_d   = actual_s;
        end else begin
            upd_jump_n_d  = 1'b1;
        end
    end

    // Recovery FSM: one-cycle redirect, then a fixed-length flush independent of stall.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict_s) begin
                    state_d          = ST_RECOVER;
                    cnt_d            = CNT_INIT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = actual_s;
                    flush_d          = 1'b1;
                end else begin
                    flush_d          = 1'b0;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
                flush_d = 1'b0;
            end
        endcase
    end

    // Output and state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 2'd0;
            upd_jump_n_q     <= 1'b1;
            upd_from_pc_q    <= 16'h0000;
            upd_to_pc_q      <= 16'h0000;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 16'h0000;
            flush_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            upd_jump_n_q     <= upd_jump_n_d;
            upd_from_pc_q    <= upd_from_pc_d;
            upd_to_pc_q      <= upd_to_pc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
        end
    end

    assign upd_jump_n     = upd_jump_n_q;
    assign upd_from_pc    = upd_from_pc_q;
    assign upd_to_pc      = upd_to_pc_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;

`ifdef BRU_STATS_EN
    logic [15:0] stat_branches_q, stat_branches_d;
    logic [15:0] stat_mispred_q, stat_mispred_d;

    // Saturating event counters.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (pop_s && id_is_branch && (stat_branches_q != STAT_MAX)) begin
            stat_branches_d = stat_branches_q + 16'd1;
        end else begin
            stat_branches_d = stat_branches_q;
        end
        if (mispredict_s && (stat_mispred_q != STAT_MAX)) begin
            stat_mispred_d = stat_mispred_q + 16'd1;
        end else begin
            stat_mispred_d = stat_mispred_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches_q <= 16'h0000;
            stat_mispred_q  <= 16'h0000;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors, queued expectations, negedge monitor.
module tb_branch_resolve_unit;

    localparam int FLUSH = 2;

    logic        clk, rst, stall, if_valid, id_valid, id_is_branch, id_taken;
    logic [15:0] if_pc, if_pred_pc, id_target;
    logic        upd_jump_n, redirect_valid, flush, fifo_ovf;
    logic [15:0] upd_from_pc, upd_to_pc, redirect_pc;
`ifdef BRU_STATS_EN
    logic [15:0] stat_branches, stat_mispred;
`endif

    typedef struct packed {
        logic        upd;
        logic [15:0] from_pc;
        logic [15:0] to_pc;
        logic        redir;
        logic [15:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(FLUSH)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pred_pc     (if_pred_pc),
        .id_valid       (id_valid),
        .id_is_branch   (id_is_branch),
        .id_taken       (id_taken),
        .id_target      (id_target),
        .upd_jump_n     (upd_jump_n),
        .upd_from_pc    (upd_from_pc),
        .upd_to_pc      (upd_to_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .fifo_ovf       (fifo_ovf)
`ifdef BRU_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Monitor: every visible update or redirect must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (rst && (!upd_jump_n || redirect_valid)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got upd_n=%b from=%h to=%h redir=%b rpc=%h, required no output",
                         upd_jump_n, upd_from_pc, upd_to_pc, redirect_valid, redirect_pc);
            end else begin
                e  = exp_q.pop_front();
                ok = (upd_jump_n == !e.upd) && (redirect_valid == e.redir) &&
                     (!e.upd || ((upd_from_pc == e.from_pc) && (upd_to_pc == e.to_pc))) &&
                     (!e.redir || (redirect_pc == e.rpc));
                if (!ok) begin
                    errors++;
                    $display("FAIL output_match: got upd_n=%b from=%h to=%h redir=%b rpc=%h, required upd_n=%b from=%h to=%h redir=%b rpc=%h",
                             upd_jump_n, upd_from_pc, upd_to_pc, redirect_valid, redirect_pc,
                             !e.upd, e.from_pc, e.to_pc, e.redir, e.rpc);
                end
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic upd, input logic [15:0] from_pc, input logic [15:0] to_pc,
                              input logic redir, input logic [15:0] rpc);
        exp_q.push_back('{upd: upd, from_pc: from_pc, to_pc: to_pc, redir: redir, rpc: rpc});
    endtask

    task automatic push(input logic [15:0] pc, input logic [15:0] pred);
        if_valid = 1'b1; if_pc = pc; if_pred_pc = pred;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic pop(input logic br, input logic taken, input logic [15:0] tgt);
        id_valid = 1'b1; id_is_branch = br; id_taken = taken; id_target = tgt;
        tick();
        id_valid = 1'b0;
    endtask

    task automatic push_pop(input logic [15:0] pc, input logic [15:0] pred,
                            input logic br, input logic taken, input logic [15:0] tgt);
        if_valid = 1'b1; if_pc = pc; if_pred_pc = pred;
        id_valid = 1'b1; id_is_branch = br; id_taken = taken; id_target = tgt;
        tick();
        if_valid = 1'b0;
        id_valid = 1'b0;
    endtask

    // Counts consecutive flush-high cycles starting at the next negedge (bounded).
    task automatic measure_flush(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (flush) n++;
            else break;
        end
    endtask

    task automatic check_empty_pop(input string name);
        pop(1'b1, 1'b0, 16'h0000);
        @(negedge clk); #1;
        chk1(name, upd_jump_n, 1'b1);
    endtask

    initial begin
        int n;
        rst = 1'b1; stall = 1'b0; if_valid = 1'b0; id_valid = 1'b0;
        id_is_branch = 1'b0; id_taken = 1'b0;
        if_pc = 16'h0000; if_pred_pc = 16'h0000; id_target = 16'h0000;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk1 ("rst_upd_jump_n", upd_jump_n, 1'b1);
        chk16("rst_upd_from", upd_from_pc, 16'h0000);
        chk16("rst_upd_to", upd_to_pc, 16'h0000);
        chk1 ("rst_redirect_valid", redirect_valid, 1'b0);
        chk16("rst_redirect_pc", redirect_pc, 16'h0000);
        chk1 ("rst_flush", flush, 1'b0);
        chk1 ("rst_fifo_ovf", fifo_ovf, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();

        // Correct not-taken branch.
        push(16'h0010, 16'h0011);
        expect_out(1'b1, 16'h0010, 16'h0011, 1'b0, 16'h0000);
        pop(1'b1, 1'b0, 16'h0000);
        @(negedge clk); #1;
        chk1("nt_flush", flush, 1'b0);

        // Correct non-branch: no table write, update fields hold.
        push(16'h0012, 16'h0013);
        pop(1'b0, 1'b0, 16'h0000);
        @(negedge clk); #1;
        chk1 ("nonbr_no_upd", upd_jump_n, 1'b1);
        chk16("nonbr_from_hold", upd_from_pc, 16'h0010);

        // Taken mispredict; fetches during the mispredict cycle and recovery must not enter.
        push(16'h0020, 16'h0021);
        if_valid = 1'b1; if_pc = 16'h0070; if_pred_pc = 16'h0071;
        expect_out(1'b1, 16'h0020, 16'h0040, 1'b1, 16'h0040);
        pop(1'b1, 1'b1, 16'h0040);
        measure_flush(n);
        if_valid = 1'b0;
        chk16("taken_flush_len", 16'(n), 16'(FLUSH));
        check_empty_pop("taken_fifo_empty");

        // Wrap: 0xFFFF + 1 = 0x0000 is a correct prediction.
        push(16'hFFFF, 16'h0000);
        expect_out(1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000);
        pop(1'b1, 1'b0, 16'h0000);
        @(negedge clk); #1;
        chk1("wrap_flush", flush, 1'b0);

        // Mispredicted non-branch: redirect only, no table write.
        push(16'h00A0, 16'h00A1);
        expect_out(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00B0);
        pop(1'b0, 1'b1, 16'h00B0);
        measure_flush(n);
        chk16("nonbr_mis_flush_len", 16'(n), 16'(FLUSH));

        // Stall held through recovery does not freeze the flush count.
        push(16'h0030, 16'h0031);
        expect_out(1'b1, 16'h0030, 16'h0050, 1'b1, 16'h0050);
        pop(1'b1, 1'b1, 16'h0050);
        stall = 1'b1; if_valid = 1'b1; if_pc = 16'h0060; if_pred_pc = 16'h0061;
        measure_flush(n);
        stall = 1'b0; if_valid = 1'b0;
        chk16("stall_flush_len", 16'(n), 16'(FLUSH));
        check_empty_pop("stall_fifo_empty");

        // Overflow: fifth push dropped, oldest four pop in order, flag sticky.
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), 16'h0101 + 16'(i));
        @(negedge clk); #1;
        chk1("ovf_full_no_flag", fifo_ovf, 1'b0);
        push(16'h0104, 16'h0105);
        @(negedge clk); #1;
        chk1("ovf_set", fifo_ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expect_out(1'b1, 16'h0100 + 16'(i), 16'h0101 + 16'(i), 1'b0, 16'h0000);
            pop(1'b1, 1'b0, 16'h0000);
        end
        @(negedge clk); #1;
        chk1("ovf_sticky", fifo_ovf, 1'b1);
        check_empty_pop("ovf_drained");

        // Reset during the first flush cycle.
        push(16'h0080, 16'h0081);
        expect_out(1'b1, 16'h0080, 16'h0090, 1'b1, 16'h0090);
        pop(1'b1, 1'b1, 16'h0090);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk1 ("midrst_flush", flush, 1'b0);
        chk1 ("midrst_redirect_valid", redirect_valid, 1'b0);
        chk1 ("midrst_upd_jump_n", upd_jump_n, 1'b1);
        chk16("midrst_redirect_pc", redirect_pc, 16'h0000);
        chk16("midrst_upd_from", upd_from_pc, 16'h0000);
        chk1 ("midrst_fifo_ovf", fifo_ovf, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        check_empty_pop("midrst_fifo_empty");

        // Push and pop together while full: no drop, order preserved.
        for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i), 16'h0201 + 16'(i));
        expect_out(1'b1, 16'h0200, 16'h0201, 1'b0, 16'h0000);
        push_pop(16'h0204, 16'h0205, 1'b1, 1'b0, 16'h0000);
        for (int i = 1; i < 5; i++) begin
            expect_out(1'b1, 16'h0200 + 16'(i), 16'h0201 + 16'(i), 1'b0, 16'h0000);
            pop(1'b1, 1'b0, 16'h0000);
        end
        @(negedge clk); #1;
        chk1("full_pushpop_no_ovf", fifo_ovf, 1'b0);

        repeat (3) @(negedge clk);
        chk16("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
